// File: rtl/rv_pkg.sv
// Shared types and defaults for the integer register file and its scoreboard.
// No timing of its own; no flow control.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/rv_scoreboard.sv
// Write-pending scoreboard: one busy bit per register plus per-port busy lookup.
// Lookup is combinational; busy updates one edge after issue or writeback. No backpressure.
// RF_BYPASS_EN: a same-cycle writeback hides busy on matching read ports.
module rv_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic             set_busy;
    logic             clr_busy;

    // Reset masks both strobes so nothing presented alongside rst survives.
    assign set_busy = iss_en && !rst && (iss_addr != AW'(ZERO_REG));
    assign clr_busy = wr_en  && !rst && (wr_addr  != AW'(ZERO_REG));

    // The set is the later assignment, so a newer producer wins over a retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            if (clr_busy) busy_q[wr_addr]  <= 1'b0;
            if (set_busy) busy_q[iss_addr] <= 1'b1;
        end
    end

    assign busy_vec = busy_q;

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = rd_en[i] & busy_q[rd_addr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
            if (rd_en[i] && clr_busy && (wr_addr == rd_addr[i*AW +: AW]))
                rd_busy[i] = set_busy && (iss_addr == wr_addr);
`endif
        end
    end

endmodule

// File: rtl/rv_regfile_sb.sv
// Integer register file (NRD combinational reads, one write, x0 = 0) with write-pending scoreboard.
// Reads 0 cycles, writes and scoreboard updates 1 edge; always accepts, no backpressure.
// RF_BYPASS_EN selects write-first forwarding; undefined returns the stored value.
module rv_regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                hazard,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs    [1:NREGS-1];
    logic [XLEN-1:0] rf_view [NREGS];
    logic            wr_fire;

    assign wr_fire = wr_en && !rst && (wr_addr != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < NREGS; k++) regs[k] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Full-size view with a constant x0 so read muxes index it directly.
    always_comb begin
        rf_view[0] = '0;
        for (int k = 1; k < NREGS; k++) rf_view[k] = regs[k];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_en[i] && (rd_addr[i*AW +: AW] != AW'(ZERO_REG))) begin
                rd_data[i*XLEN +: XLEN] = rf_view[rd_addr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
                if (wr_fire && (wr_addr == rd_addr[i*AW +: AW]))
                    rd_data[i*XLEN +: XLEN] = wr_data;
`endif
            end
        end
    end

    rv_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

    // rd_busy is already gated by rd_en.
    assign hazard = |rd_busy;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Scoreboarded bench for rv_regfile_sb: directed scenarios then random traffic vs. an array model.
module tb_rv_regfile_sb;
    import rv_pkg::*;

    localparam int NRD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  rd_en = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hazard;
    logic        wr_en = 1'b0;
    reg_addr_t   wr_addr = '0;
    xword_t      wr_data = '0;
    logic        iss_en = 1'b0;
    reg_addr_t   iss_addr = '0;
    logic [31:0] busy_vec;

    always #5 clk = ~clk;

    rv_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(NRD)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .hazard   (hazard),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    typedef struct packed {
        logic [31:0] id;
        logic [63:0] data;
        logic [1:0]  busy;
        logic        hz;
        logic [31:0] bv;
    } exp_t;

    exp_t exp_q[$];

    // Architectural model: plain arrays of register values and pending-write flags.
    bit [31:0] m_regs [32];
    bit        m_busy [32];

    int vectors     = 0;
    int miscompares = 0;
    int step_id     = 0;

    task automatic step(input bit r, input bit [1:0] re, input bit [4:0] a0, input bit [4:0] a1,
                        input bit we, input bit [4:0] wa, input bit [31:0] wd,
                        input bit ie, input bit [4:0] ia, input bit chk);
        exp_t e;
        bit [4:0] a;
        bit [31:0] d;
        bit b;
        @(posedge clk);
        #1;
        rst = r; rd_en = re; rd_addr = {a1, a0};
        wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_addr = ia;
        step_id++;
        if (chk) begin
            e = '0;
            e.id = step_id;
            for (int i = 0; i < NRD; i++) begin
                a = (i == 0) ? a0 : a1;
                d = 0; b = 0;
                if (re[i] && a != 0) begin
                    d = m_regs[a];
                    b = m_busy[a];
`ifdef RF_BYPASS_EN
                    if (we && !r && wa == a) begin
                        d = wd;
                        b = ie && ia == a;
                    end
`endif
                end
                e.data[i*32 +: 32] = d;
                e.busy[i] = b;
            end
            e.hz = |e.busy;
            for (int k = 0; k < 32; k++) e.bv[k] = m_busy[k];
            exp_q.push_back(e);
        end
        if (r) begin
            for (int k = 0; k < 32; k++) begin m_regs[k] = 0; m_busy[k] = 0; end
        end else begin
            if (we && wa != 0) begin m_regs[wa] = wd; m_busy[wa] = 0; end
            if (ie && ia != 0) m_busy[ia] = 1;
        end
    endtask

    task automatic idle_read(input bit [1:0] re, input bit [4:0] a0, input bit [4:0] a1);
        step(0, re, a0, a1, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: outputs are combinational, so every negedge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (rd_data !== e.data) begin
                    miscompares++;
                    $display("FAIL rd_data step %0d: got %h want %h", e.id, rd_data, e.data);
                end
                vectors++;
                if (rd_busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL rd_busy step %0d: got %b want %b", e.id, rd_busy, e.busy);
                end
                vectors++;
                if (hazard !== e.hz) begin
                    miscompares++;
                    $display("FAIL hazard step %0d: got %b want %b", e.id, hazard, e.hz);
                end
                vectors++;
                if (busy_vec !== e.bv) begin
                    miscompares++;
                    $display("FAIL busy_vec step %0d: got %h want %h", e.id, busy_vec, e.bv);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [4:0] ra0, ra1, wa, ia;
        // Pre-reset outputs are undefined, so the reset cycle itself is not checked.
        step(1, 2'b11, 1, 2, 0, 0, 0, 0, 0, 0);
        for (int a = 1; a < 32; a++) idle_read(2'b11, 5'(a), 5'(32 - a));

        step(0, 2'b00, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 1);
        idle_read(2'b11, 5, 0);
        step(0, 2'b00, 0, 0, 1, 0, 32'h1234, 0, 0, 1);
        idle_read(2'b11, 0, 0);

        step(0, 2'b00, 0, 0, 0, 0, 0, 1, 7, 1);
        idle_read(2'b01, 7, 0);
        step(0, 2'b11, 7, 7, 1, 7, 32'h42, 0, 0, 1);
        idle_read(2'b11, 7, 7);

        step(0, 2'b01, 9, 0, 1, 9, 32'h11, 1, 9, 1);
        idle_read(2'b11, 9, 9);
        // Bypass with set-wins: the same-cycle writeback is forwarded but busy stays.
        step(0, 2'b01, 9, 0, 1, 9, 32'h22, 1, 9, 1);
        idle_read(2'b01, 9, 0);

        step(0, 2'b00, 0, 0, 1, 3, 32'h5, 1, 3, 1);
        step(0, 2'b00, 0, 0, 1, 4, 32'h6, 1, 4, 1);
        step(1, 2'b11, 3, 4, 1, 8, 32'h77, 1, 6, 1);
        idle_read(2'b11, 3, 4);
        idle_read(2'b11, 6, 8);

        step(0, 2'b00, 0, 0, 0, 0, 0, 1, 10, 1);
        idle_read(2'b00, 10, 10);
        idle_read(2'b10, 0, 10);

        for (int n = 0; n < 2000; n++) begin
            ra0 = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 31));
            wa  = 5'($urandom_range(0, 31));
            ia  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) ra0 = wa;
            step($urandom_range(0, 99) == 0, 2'($urandom_range(0, 3)), ra0, ra1,
                 $urandom_range(0, 1) == 1, wa, $urandom,
                 $urandom_range(0, 2) == 0, ia, 1);
        end

        @(posedge clk);
        #1;
        rd_en = '0; wr_en = 1'b0; iss_en = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_regfile_sb.md
# rv_regfile_sb

Parametrised integer register file for the decode stage, with a built-in write-pending scoreboard. It provides NRD combinational read ports and one synchronous write port, with x0 hardwired to zero. A per-register busy bit is set when decode issues an instruction that writes rd and cleared at writeback. It replaces the single-cycle, unscoreboarded register file and drives the decode hazard/stall logic.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), address width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset: synchronous, active-high
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  per-port: the addressed register has a write pending
- hazard  out  1  OR over i of (rd_en[i] & rd_busy[i])
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- iss_en  in  1  decode issues an instruction that writes iss_addr
- iss_addr  in  AW  destination of the issued instruction
- busy_vec  out  NREGS  raw scoreboard, for debug/perf counters

## Operation
- Storage: regs[1..NREGS-1] are flops. regs[0] reads as 0 and is never written.
- Write: regs[wr_addr] <= wr_data at the clock edge when wr_en && wr_addr != 0.
- Read, combinational:
  - rd_data[i] = 0 if !rd_en[i] or rd_addr[i] == 0.
  - Otherwise rd_data[i] = regs[rd_addr[i]], subject to the bypass described under Configuration.
- Scoreboard `busy[NREGS]`, updated each edge:
  - set busy[iss_addr] if iss_en && iss_addr != 0;
  - clear busy[wr_addr] if wr_en && wr_addr != 0;
  - if set and clear hit the same address in the same cycle, set wins (a newer producer has been issued).
  - busy[0] is constant 0.
- rd_busy[i] = rd_en[i] & busy[rd_addr[i]], subject to the bypass described under Configuration. rd_busy[i] is 0 when rd_en[i] is 0.
- Writeback to a non-busy register is legal: the data is written and busy is unaffected.
- Issue to an already-busy register is legal (WAW): busy stays 1.
- Contract: the first writeback clears busy. Upstream guarantees in-order writeback per register.

## Timing
- Read latency: 0 cycles (same-cycle combinational).
- Write latency: 1 edge. Without bypass, data is visible to reads in the cycle after wr_en.
- Scoreboard latency: an issue in cycle N gives busy=1 from cycle N+1. A same-cycle read of that register in cycle N sees the pre-issue state.
- Reset, synchronous: at the first edge with rst=1, all regs become 0 and busy_vec becomes 0.
  - rd_data then reads as 0 on every port; rd_busy, hazard and busy_vec read as 0.
  - While rst is high, wr_en and iss_en are ignored.
  - A write or issue presented in the cycle rst is asserted is dropped.

## Configuration
- Macro RF_BYPASS_EN.
- Defined (write-first forwarding): if wr_en && wr_addr == rd_addr[i] && wr_addr != 0, then:
  - rd_data[i] = wr_data in the same cycle;
  - rd_busy[i] = 0 in the same cycle, unless busy would stay set because iss_en targets the same address (set-wins rule). In that case rd_busy[i] = 1 and rd_data[i] is still wr_data.
- Undefined (read-old): rd_data[i] returns the stored value and rd_busy[i] reflects the current busy bit. The writeback becomes usable one cycle later.
- hazard follows rd_busy in both modes.

## Structure
- Package rv_pkg holds:
  - localparams XLEN_DEF=32 and NREGS_DEF=32;
  - typedef reg_addr_t (logic [4:0]) and typedef xword_t (logic [XLEN_DEF-1:0]);
  - localparam ZERO_REG=0.
- One sub-module, rv_scoreboard (busy vector set/clear plus per-port lookup), parametrised by NREGS, NRD and AW. The data array and read muxes stay in the top module.

## Test plan
- Reset, then read x1..x31 on all ports -> every rd_data == 0, busy_vec == 0, hazard == 0.
- Write x5=0xDEADBEEF, next cycle read x5 on port 0 and x0 on port 1 -> 0xDEADBEEF and 0. A write to x0 of 0x1234 -> x0 still reads 0.
- Issue x7 in cycle 1, read x7 in cycle 2 -> rd_busy[0]=1, hazard=1. Writeback x7=0x42 in cycle 3 -> with RF_BYPASS_EN: rd_data=0x42, rd_busy=0 in cycle 3; without: old value and busy=1 in cycle 3, then 0x42 and busy=0 in cycle 4.
- Issue x9 and writeback x9=0x11 in the same cycle -> busy_vec[9]=1 next cycle, and regs[9]=0x11.
- With busy x3 and x4, regs nonzero, assert rst for 1 cycle alongside iss_en x6 -> all regs 0, busy_vec == 0, and x6 not busy afterwards.
- Read enables low with rd_addr pointing at a busy register -> rd_data 0, rd_busy 0, hazard 0.
